// File: rtl/sig_trace_writer.sv
// sig_trace_writer: decimates the ECG and EMG sample streams and writes them in sweep order
// into the two display windows of the shared signal memory. After reset, or on clear_req,
// both windows are filled with mid-scale so the display never shows stale data.
module sig_trace_writer #(
    parameter logic [11:0] ECG_BASE = 12'h559,
    parameter logic [11:0] EMG_BASE = 12'h6AD,
    parameter int unsigned POINTS   = 320,
    parameter int unsigned DECIM    = 4,
    parameter logic [11:0] MID_VAL  = 12'h800
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ecg_valid,
    input  logic [11:0] i_ecg_data,
    output logic        o_ecg_ready,
    input  logic        i_emg_valid,
    input  logic [11:0] i_emg_data,
    output logic        o_emg_ready,
    input  logic        i_freeze,
    input  logic        i_clear_req,
    output logic        o_mem_wEn,
    output logic [11:0] o_mem_addr,
    output logic [31:0] o_mem_dataOut,
    output logic        o_ecg_sweep_done,
    output logic        o_emg_sweep_done,
    output logic        o_busy
);

    localparam int unsigned IW = $clog2(POINTS);
    localparam int unsigned CW = $clog2(2 * POINTS);
    localparam logic [IW-1:0] IDX_LAST = IW'(POINTS - 1);
    localparam logic [CW-1:0] CLR_HALF = CW'(POINTS);
    localparam logic [CW-1:0] CLR_LAST = CW'(2 * POINTS - 1);
    localparam logic [7:0]    DEC_LAST = 8'(DECIM - 1);

    typedef enum logic [1:0] {StClear, StRun, StFrozen} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_c, w_c_nxt;
    logic [IW-1:0] r_ecg_idx, r_emg_idx, w_ecg_idx_nxt, w_emg_idx_nxt;
    logic [7:0]    r_ecg_dec, r_emg_dec, w_ecg_dec_nxt, w_emg_dec_nxt;
    logic          r_ecg_hold_v, r_emg_hold_v, w_ecg_hold_v_nxt, w_emg_hold_v_nxt;
    logic [11:0]   r_ecg_hold, r_emg_hold, w_ecg_hold_nxt, w_emg_hold_nxt;
    logic          r_rr_emg, w_rr_nxt;
    logic          r_wen, w_wen_nxt;
    logic [11:0]   r_addr, w_addr_nxt;
    logic [11:0]   r_data, w_data_nxt;
    logic          r_ecg_done, r_emg_done, w_ecg_done_nxt, w_emg_done_nxt;
    logic          r_busy;

    logic          w_ecg_ready, w_emg_ready;
    logic          w_ecg_acc, w_emg_acc;
    logic          w_ecg_cand, w_emg_cand;
    logic          w_ecg_grant, w_emg_grant;
    logic [11:0]   w_ecg_val, w_emg_val;
    logic [7:0]    w_ecg_dec_inc, w_emg_dec_inc;

    // Ready comes only from registered state, so it never depends on the valid inputs.
    assign w_ecg_ready = (r_state == StFrozen) | ((r_state == StRun) & ~r_ecg_hold_v);
    assign w_emg_ready = (r_state == StFrozen) | ((r_state == StRun) & ~r_emg_hold_v);
    assign w_ecg_acc   = i_ecg_valid & w_ecg_ready;
    assign w_emg_acc   = i_emg_valid & w_emg_ready;

    // A channel wants a write if it holds a loser from last cycle or takes a kept sample now;
    // the fresh sample bypasses the holding register so an uncontested write costs one cycle.
    assign w_ecg_cand  = (r_state == StRun) & (r_ecg_hold_v | (w_ecg_acc & (r_ecg_dec == 8'd0)));
    assign w_emg_cand  = (r_state == StRun) & (r_emg_hold_v | (w_emg_acc & (r_emg_dec == 8'd0)));
    assign w_ecg_val   = r_ecg_hold_v ? r_ecg_hold : i_ecg_data;
    assign w_emg_val   = r_emg_hold_v ? r_emg_hold : i_emg_data;
    assign w_ecg_grant = w_ecg_cand & (~w_emg_cand | ~r_rr_emg);
    assign w_emg_grant = w_emg_cand & ~w_ecg_grant;

    assign w_ecg_dec_inc = (r_ecg_dec == DEC_LAST) ? 8'd0 : r_ecg_dec + 8'd1;
    assign w_emg_dec_inc = (r_emg_dec == DEC_LAST) ? 8'd0 : r_emg_dec + 8'd1;

    // Next-state logic and write-port decode for CLEAR / RUN / FROZEN.
    always_comb begin
        w_state_nxt      = r_state;
        w_c_nxt          = r_c;
        w_ecg_idx_nxt    = r_ecg_idx;
        w_emg_idx_nxt    = r_emg_idx;
        w_ecg_dec_nxt    = r_ecg_dec;
        w_emg_dec_nxt    = r_emg_dec;
        w_ecg_hold_v_nxt = r_ecg_hold_v;
        w_emg_hold_v_nxt = r_emg_hold_v;
        w_ecg_hold_nxt   = r_ecg_hold;
        w_emg_hold_nxt   = r_emg_hold;
        w_rr_nxt         = r_rr_emg;
        w_wen_nxt        = 1'b0;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_ecg_done_nxt   = 1'b0;
        w_emg_done_nxt   = 1'b0;

        unique case (r_state)
            StClear: begin
                if (i_clear_req) begin
                    w_c_nxt = '0;
                end else begin
                    w_wen_nxt  = 1'b1;
                    w_data_nxt = MID_VAL;
                    w_addr_nxt = (r_c < CLR_HALF) ? ECG_BASE + 12'(r_c)
                                                  : EMG_BASE + 12'(r_c - CLR_HALF);
                    if (r_c == CLR_LAST) begin
                        w_state_nxt   = i_freeze ? StFrozen : StRun;
                        w_c_nxt       = '0;
                        w_ecg_idx_nxt = '0;
                        w_emg_idx_nxt = '0;
                        w_ecg_dec_nxt = 8'd0;
                        w_emg_dec_nxt = 8'd0;
                    end else begin
                        w_c_nxt = r_c + 1'b1;
                    end
                end
            end

            StRun: begin
                if (i_clear_req) begin
                    w_state_nxt      = StClear;
                    w_c_nxt          = '0;
                    w_ecg_hold_v_nxt = 1'b0;
                    w_emg_hold_v_nxt = 1'b0;
                end else begin
                    if (w_ecg_acc) w_ecg_dec_nxt = w_ecg_dec_inc;
                    if (w_emg_acc) w_emg_dec_nxt = w_emg_dec_inc;
                    w_ecg_hold_v_nxt = w_ecg_cand & ~w_ecg_grant;
                    w_emg_hold_v_nxt = w_emg_cand & ~w_emg_grant;
                    w_ecg_hold_nxt   = w_ecg_val;
                    w_emg_hold_nxt   = w_emg_val;
                    // Priority flips only when both channels actually contend.
                    if (w_ecg_cand & w_emg_cand) w_rr_nxt = ~r_rr_emg;
                    if (w_ecg_grant) begin
                        w_wen_nxt      = 1'b1;
                        w_addr_nxt     = ECG_BASE + 12'(r_ecg_idx);
                        w_data_nxt     = w_ecg_val;
                        w_ecg_done_nxt = (r_ecg_idx == IDX_LAST);
                        w_ecg_idx_nxt  = (r_ecg_idx == IDX_LAST) ? '0 : r_ecg_idx + 1'b1;
                    end else if (w_emg_grant) begin
                        w_wen_nxt      = 1'b1;
                        w_addr_nxt     = EMG_BASE + 12'(r_emg_idx);
                        w_data_nxt     = w_emg_val;
                        w_emg_done_nxt = (r_emg_idx == IDX_LAST);
                        w_emg_idx_nxt  = (r_emg_idx == IDX_LAST) ? '0 : r_emg_idx + 1'b1;
                    end
                    // Freeze takes effect only once no contest loser is left in flight.
                    if (i_freeze & ~w_ecg_hold_v_nxt & ~w_emg_hold_v_nxt) begin
                        w_state_nxt = StFrozen;
                    end
                end
            end

            StFrozen: begin
                if (i_clear_req) begin
                    w_state_nxt      = StClear;
                    w_c_nxt          = '0;
                    w_ecg_hold_v_nxt = 1'b0;
                    w_emg_hold_v_nxt = 1'b0;
                end else if (!i_freeze) begin
                    w_state_nxt = StRun;
                end
            end

            default: begin
                w_state_nxt = StClear;
                w_c_nxt     = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered write-port outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_c          <= '0;
            r_ecg_idx    <= '0;
            r_emg_idx    <= '0;
            r_ecg_dec    <= 8'd0;
            r_emg_dec    <= 8'd0;
            r_ecg_hold_v <= 1'b0;
            r_emg_hold_v <= 1'b0;
            r_ecg_hold   <= 12'd0;
            r_emg_hold   <= 12'd0;
            r_rr_emg     <= 1'b0;
            r_wen        <= 1'b0;
            r_addr       <= 12'd0;
            r_data       <= 12'd0;
            r_ecg_done   <= 1'b0;
            r_emg_done   <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_c          <= w_c_nxt;
            r_ecg_idx    <= w_ecg_idx_nxt;
            r_emg_idx    <= w_emg_idx_nxt;
            r_ecg_dec    <= w_ecg_dec_nxt;
            r_emg_dec    <= w_emg_dec_nxt;
            r_ecg_hold_v <= w_ecg_hold_v_nxt;
            r_emg_hold_v <= w_emg_hold_v_nxt;
            r_ecg_hold   <= w_ecg_hold_nxt;
            r_emg_hold   <= w_emg_hold_nxt;
            r_rr_emg     <= w_rr_nxt;
            r_wen        <= w_wen_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_ecg_done   <= w_ecg_done_nxt;
            r_emg_done   <= w_emg_done_nxt;
            // Lags the state by one cycle so busy stays aligned with the last fill write.
            r_busy       <= (r_state == StClear);
        end
    end

    assign o_ecg_ready      = w_ecg_ready;
    assign o_emg_ready      = w_emg_ready;
    assign o_mem_wEn        = r_wen;
    assign o_mem_addr       = r_addr;
    assign o_mem_dataOut    = {20'd0, r_data};
    assign o_ecg_sweep_done = r_ecg_done;
    assign o_emg_sweep_done = r_emg_done;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_sig_trace_writer.sv
// Bench for sig_trace_writer: two instances (DECIM=4 and DECIM=1) share one stimulus stream
// and are checked every cycle against a behavioural model, plus directed scenario checks.
module tb_sig_trace_writer;

    localparam int ECG_B  = 12'h559;
    localparam int EMG_B  = 12'h6AD;
    localparam int PTS    = 320;
    localparam int MIDV   = 12'h800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        ecg_valid = 1'b0;
    logic [11:0] ecg_data  = 12'd0;
    logic        emg_valid = 1'b0;
    logic [11:0] emg_data  = 12'd0;
    logic        freeze    = 1'b0;
    logic        clear_req = 1'b0;

    logic        d_ecg_rdy [2];
    logic        d_emg_rdy [2];
    logic        d_wen     [2];
    logic [11:0] d_addr    [2];
    logic [31:0] d_data    [2];
    logic        d_edone   [2];
    logic        d_mdone   [2];
    logic        d_busy    [2];

    sig_trace_writer #(.DECIM(4)) u_dut4 (
        .i_clock(clk), .i_reset(rst),
        .i_ecg_valid(ecg_valid), .i_ecg_data(ecg_data), .o_ecg_ready(d_ecg_rdy[0]),
        .i_emg_valid(emg_valid), .i_emg_data(emg_data), .o_emg_ready(d_emg_rdy[0]),
        .i_freeze(freeze), .i_clear_req(clear_req),
        .o_mem_wEn(d_wen[0]), .o_mem_addr(d_addr[0]), .o_mem_dataOut(d_data[0]),
        .o_ecg_sweep_done(d_edone[0]), .o_emg_sweep_done(d_mdone[0]), .o_busy(d_busy[0])
    );

    sig_trace_writer #(.DECIM(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst),
        .i_ecg_valid(ecg_valid), .i_ecg_data(ecg_data), .o_ecg_ready(d_ecg_rdy[1]),
        .i_emg_valid(emg_valid), .i_emg_data(emg_data), .o_emg_ready(d_emg_rdy[1]),
        .i_freeze(freeze), .i_clear_req(clear_req),
        .o_mem_wEn(d_wen[1]), .o_mem_addr(d_addr[1]), .o_mem_dataOut(d_data[1]),
        .o_ecg_sweep_done(d_edone[1]), .o_emg_sweep_done(d_mdone[1]), .o_busy(d_busy[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model. mode: 0 = filling, 1 = running, 2 = frozen. ch 0 = ECG, 1 = EMG.
    int m_mode [2];
    int m_c    [2];
    int m_idx  [2][2];
    int m_cnt  [2][2];
    bit m_pend [2][2];
    int m_pval [2][2];
    int m_pri  [2];
    bit e_wen  [2];
    int e_addr [2];
    int e_data [2];
    bit e_done [2][2];
    bit e_busy [2];

    function automatic bit m_ready(int k, int ch);
        return (m_mode[k] == 2) || (m_mode[k] == 1 && !m_pend[k][ch]);
    endfunction

    task automatic model_step(int k);
        int  dec;
        int  base [2];
        bit  vld  [2];
        int  din  [2];
        bit  acc  [2];
        bit  want [2];
        int  val  [2];
        int  win;
        dec     = (k == 0) ? 4 : 1;
        base[0] = ECG_B;
        base[1] = EMG_B;
        vld[0]  = ecg_valid;
        vld[1]  = emg_valid;
        din[0]  = int'(ecg_data);
        din[1]  = int'(emg_data);
        if (rst) begin
            m_mode[k] = 0; m_c[k] = 0; m_pri[k] = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_idx[k][ch] = 0; m_cnt[k][ch] = 0; m_pend[k][ch] = 0; e_done[k][ch] = 0;
            end
            e_wen[k] = 0; e_addr[k] = 0; e_data[k] = 0; e_busy[k] = 1;
            return;
        end
        e_busy[k] = (m_mode[k] == 0);
        e_wen[k]  = 0;
        for (int ch = 0; ch < 2; ch++) begin
            e_done[k][ch] = 0;
            acc[ch]       = vld[ch] && m_ready(k, ch);
        end
        if (m_mode[k] != 0 && clear_req) begin
            m_mode[k] = 0; m_c[k] = 0; m_pend[k][0] = 0; m_pend[k][1] = 0;
        end else if (m_mode[k] == 0) begin
            if (clear_req) begin
                m_c[k] = 0;
            end else begin
                e_wen[k]  = 1;
                e_data[k] = MIDV;
                e_addr[k] = (m_c[k] < PTS) ? ECG_B + m_c[k] : EMG_B + m_c[k] - PTS;
                if (m_c[k] == 2 * PTS - 1) begin
                    m_mode[k] = freeze ? 2 : 1;
                    m_c[k]    = 0;
                    for (int ch = 0; ch < 2; ch++) begin
                        m_idx[k][ch] = 0; m_cnt[k][ch] = 0;
                    end
                end else begin
                    m_c[k]++;
                end
            end
        end else if (m_mode[k] == 1) begin
            for (int ch = 0; ch < 2; ch++) begin
                want[ch] = m_pend[k][ch];
                val[ch]  = m_pval[k][ch];
                if (acc[ch]) begin
                    if (m_cnt[k][ch] == 0) begin
                        want[ch] = 1;
                        val[ch]  = din[ch];
                    end
                    m_cnt[k][ch] = (m_cnt[k][ch] + 1) % dec;
                end
            end
            if (want[0] || want[1]) begin
                if (want[0] && want[1]) begin
                    win               = m_pri[k];
                    m_pri[k]          = 1 - m_pri[k];
                    m_pend[k][1-win]  = 1;
                    m_pval[k][1-win]  = val[1-win];
                end else begin
                    win = want[0] ? 0 : 1;
                end
                m_pend[k][win]  = 0;
                e_wen[k]        = 1;
                e_addr[k]       = base[win] + m_idx[k][win];
                e_data[k]       = val[win];
                e_done[k][win]  = (m_idx[k][win] == PTS - 1);
                m_idx[k][win]   = (m_idx[k][win] + 1) % PTS;
            end
            if (freeze && !m_pend[k][0] && !m_pend[k][1]) m_mode[k] = 2;
        end else begin
            if (!freeze) m_mode[k] = 1;
        end
    endtask

    // Write logs for directed checks: {addr, data[11:0]} and the cycle it was seen.
    int          cyc = 0;
    logic [23:0] wlog0[$];
    logic [23:0] wlog1[$];
    int          wcyc1[$];
    int          edone1 = 0;

    function automatic logic [23:0] at0(int i);
        if (i >= 0 && i < wlog0.size()) return wlog0[i];
        return 24'hFFFFFF;
    endfunction

    function automatic logic [23:0] at1(int i);
        if (i >= 0 && i < wlog1.size()) return wlog1[i];
        return 24'hFFFFFF;
    endfunction

    // Model advances on each rising edge; outputs are compared 2 ns later.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #2;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("d%0d_wen@%0d", k, cyc), 32'(d_wen[k]), 32'(e_wen[k]));
                if (e_wen[k]) begin
                    chk($sformatf("d%0d_addr@%0d", k, cyc), 32'(d_addr[k]), 32'(e_addr[k]));
                    chk($sformatf("d%0d_data@%0d", k, cyc), d_data[k], 32'(e_data[k]));
                end
                chk($sformatf("d%0d_edone@%0d", k, cyc), 32'(d_edone[k]), 32'(e_done[k][0]));
                chk($sformatf("d%0d_mdone@%0d", k, cyc), 32'(d_mdone[k]), 32'(e_done[k][1]));
                chk($sformatf("d%0d_busy@%0d", k, cyc), 32'(d_busy[k]), 32'(e_busy[k]));
                chk($sformatf("d%0d_erdy@%0d", k, cyc), 32'(d_ecg_rdy[k]), 32'(m_ready(k, 0)));
                chk($sformatf("d%0d_mrdy@%0d", k, cyc), 32'(d_emg_rdy[k]), 32'(m_ready(k, 1)));
            end
            if (d_wen[0] === 1'b1) wlog0.push_back({d_addr[0], d_data[0][11:0]});
            if (d_wen[1] === 1'b1) begin
                wlog1.push_back({d_addr[1], d_data[1][11:0]});
                wcyc1.push_back(cyc);
            end
            if (d_edone[1] === 1'b1) edone1++;
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        idle(645);
    endtask

    int m0, m1, f1, t0, e0;

    initial begin
        // Reset state
        idle(3);
        chk("rst_busy", 32'(d_busy[1]), 32'd1);
        chk("rst_wen", 32'(d_wen[1]), 32'd0);
        chk("rst_rdy", 32'(d_ecg_rdy[0]), 32'd0);
        rst = 1'b0;

        // Fill after reset
        idle(645);
        chk("clr_count", 32'(wlog1.size()), 32'd640);
        chk("clr_first", 32'(at1(0)), 32'h559800);
        chk("clr_ecg_last", 32'(at1(319)), 32'h698800);
        chk("clr_emg_first", 32'(at1(320)), 32'h6AD800);
        chk("clr_last", 32'(at1(639)), 32'h7EC800);
        chk("clr_gap", 32'(wcyc1[639] - wcyc1[0]), 32'd639);

        // Decimation: 8 back-to-back ECG samples
        m0 = wlog0.size(); m1 = wlog1.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); ecg_valid = 1'b1; ecg_data = 12'(12'h100 + i);
        end
        @(negedge clk); ecg_valid = 1'b0;
        idle(3);
        chk("dec4_count", 32'(wlog0.size() - m0), 32'd2);
        chk("dec4_w0", 32'(at0(m0)), 32'h559100);
        chk("dec4_w1", 32'(at0(m0 + 1)), 32'h55A104);
        chk("dec1_count", 32'(wlog1.size() - m1), 32'd8);

        // Arbitration between simultaneous offers
        do_clear();
        m1 = wlog1.size();
        @(negedge clk); ecg_valid = 1'b1; emg_valid = 1'b1; ecg_data = 12'h111; emg_data = 12'h222;
        t0 = cyc;
        @(negedge clk); ecg_valid = 1'b0; emg_valid = 1'b0;
        idle(3);
        @(negedge clk); ecg_valid = 1'b1; emg_valid = 1'b1; ecg_data = 12'h333; emg_data = 12'h444;
        @(negedge clk); ecg_valid = 1'b0; emg_valid = 1'b0;
        idle(3);
        chk("arb_count", 32'(wlog1.size() - m1), 32'd4);
        chk("arb_w0", 32'(at1(m1)), 32'h559111);
        chk("arb_w1", 32'(at1(m1 + 1)), 32'h6AD222);
        chk("arb_lat0", 32'(wcyc1[m1] - t0), 32'd1);
        chk("arb_lat1", 32'(wcyc1[m1 + 1] - t0), 32'd2);
        chk("arb_w2", 32'(at1(m1 + 2)), 32'h6AE444);
        chk("arb_w3", 32'(at1(m1 + 3)), 32'h55A333);

        // Index wrap with 321 ECG samples
        do_clear();
        m1 = wlog1.size(); e0 = edone1;
        for (int i = 0; i < 321; i++) begin
            @(negedge clk); ecg_valid = 1'b1; ecg_data = 12'(i);
        end
        @(negedge clk); ecg_valid = 1'b0;
        idle(3);
        chk("wrap_count", 32'(wlog1.size() - m1), 32'd321);
        chk("wrap_w320", 32'(at1(m1 + 319)), 32'h69813F);
        chk("wrap_w321", 32'(at1(m1 + 320)), 32'h559140);
        chk("wrap_done_cnt", 32'(edone1 - e0), 32'd1);

        // Freeze
        do_clear();
        m1 = wlog1.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); ecg_valid = 1'b1; ecg_data = 12'(12'h050 + i);
        end
        @(negedge clk); ecg_valid = 1'b0;
        idle(2);
        @(negedge clk); freeze = 1'b1;
        idle(2);
        f1 = wlog1.size();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); ecg_valid = 1'b1; ecg_data = 12'($urandom);
            chk("frz_ready", 32'(d_ecg_rdy[1]), 32'd1);
        end
        @(negedge clk); ecg_valid = 1'b0;
        chk("frz_writes", 32'(wlog1.size() - f1), 32'd0);
        freeze = 1'b0;
        idle(2);
        @(negedge clk); ecg_valid = 1'b1; ecg_data = 12'hABC;
        @(negedge clk); ecg_valid = 1'b0;
        idle(3);
        chk("frz_resume", 32'(at1(wlog1.size() - 1)), 32'h563ABC);
        chk("frz_count", 32'(wlog1.size() - m1), 32'd11);

        // clear_req in the middle of a fill
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        for (int i = 0; i < 1000 && m_c[1] != 300; i++) @(negedge clk);
        chk("clrmid_reach", 32'(m_c[1]), 32'd300);
        clear_req = 1'b1;
        m1 = wlog1.size();
        @(negedge clk); clear_req = 1'b0;
        idle(645);
        chk("clrmid_prev", 32'(at1(m1 - 1)), 32'h684800);
        chk("clrmid_restart", 32'(at1(m1)), 32'h559800);
        chk("clrmid_count", 32'(wlog1.size() - m1), 32'd640);

        // Reset while an EMG hold is pending
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(645);
        m1 = wlog1.size();
        @(negedge clk); ecg_valid = 1'b1; emg_valid = 1'b1; ecg_data = 12'h3E1; emg_data = 12'h2EE;
        @(negedge clk); ecg_valid = 1'b0; emg_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(645);
        chk("rsth_ecg", 32'(at1(m1)), 32'h5593E1);
        chk("rsth_next", 32'(at1(m1 + 1)), 32'h559800);
        chk("rsth_count", 32'(wlog1.size() - m1), 32'd641);

        // Randomized traffic with occasional freeze and clear
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ecg_valid = ($urandom_range(0, 9) < 6);
            ecg_data  = 12'($urandom);
            emg_valid = ($urandom_range(0, 9) < 6);
            emg_data  = 12'($urandom);
            if ($urandom_range(0, 99) == 0) freeze = ~freeze;
            clear_req = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        ecg_valid = 1'b0; emg_valid = 1'b0; freeze = 1'b0; clear_req = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sig_trace_writer.md
Name: sig_trace_writer

Overview:
- Upstream feeder for the VGA waveform display.
- Accepts 12-bit ECG and EMG samples over valid/ready handshakes and decimates each channel.
- Writes samples in sweep (oscilloscope) order into the shared signal memory at the two 320-point display windows.
- Also initialises both windows to mid-scale after reset or on request, so the display never shows stale data.

Parameters:
ECG_BASE, 12'h559, first memory word of the ECG window
EMG_BASE, 12'h6AD, first memory word of the EMG window
POINTS, 320, samples per window (index range 0..POINTS-1)
DECIM, 4, write one of every DECIM accepted samples per channel (1..255)
MID_VAL, 12'h800, fill value written during clear

Ports:
clock  in  1  system clock (100 MHz domain)
reset  in  1  synchronous, active-high
ecg_valid  in  1  ECG sample offered
ecg_data  in  12  ECG sample, unsigned
ecg_ready  out  1  ECG sample accepted when valid&ready
emg_valid  in  1  EMG sample offered
emg_data  in  12  EMG sample, unsigned
emg_ready  out  1  EMG sample accepted when valid&ready
freeze  in  1  level; hold display contents
clear_req  in  1  one-cycle pulse; re-run the mid-scale fill
mem_wEn  out  1  memory write strobe
mem_addr  out  12  memory write address
mem_dataOut  out  32  write data, {20'd0, sample[11:0]}
ecg_sweep_done  out  1  one-cycle pulse when ECG index wraps
emg_sweep_done  out  1  one-cycle pulse when EMG index wraps
busy  out  1  high while in CLEAR

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: ready=0, mem_wEn=0, mem_addr=0, mem_dataOut=0, sweep_done=0, busy=1.
  - Internal: indices=0, decimation counters=0, holding registers empty, rr_pri=ECG, state=CLEAR, clear counter=0.
  - Reset mid-write or mid-clear abandons the operation; no partial write occurs in the cycle after reset.
- FSM states: CLEAR, RUN, FROZEN.
- CLEAR:
  - ready=0, busy=1.
  - One write per cycle, mem_dataOut={20'd0,MID_VAL}.
  - Clear counter c runs 0..2*POINTS-1. Address = ECG_BASE+c for c<POINTS, else EMG_BASE+(c-POINTS).
  - After the write with c=2*POINTS-1: state becomes RUN (FROZEN if freeze=1); busy drops the next cycle.
  - Indices and decimation counters are forced to 0 on exit.
- RUN:
  - ready_ch = !hold_valid_ch.
  - On handshake: if dec_cnt_ch==0, the sample is latched into the channel holding register. dec_cnt_ch increments modulo DECIM on every accepted sample.
  - Write arbitration: one write per cycle. If exactly one hold is valid, write it. If both are valid, the rr_pri channel wins, then rr_pri toggles.
  - Write addr = BASE_ch + idx_ch. The hold clears in the same cycle.
  - idx_ch increments and wraps POINTS-1 -> 0. On the wrap write, sweep_done_ch pulses for exactly that cycle.
  - Latency: a sample handshaken in cycle N appears on mem_wEn/addr/data in cycle N+1 if uncontested, N+2 if it loses arbitration.
  - A new handshake on a channel whose hold is granted in cycle N is possible in cycle N+1 (ready is registered from hold state).
- FROZEN (entered when freeze=1 in RUN):
  - ready=1 on both channels; samples are accepted and discarded.
  - No writes; indices and decimation counters held.
  - Any pending hold is written before the freeze takes effect (finish in-flight, then stop).
  - freeze=0 returns to RUN.
- clear_req in RUN or FROZEN: next state is CLEAR, pending holds are dropped, c=0. clear_req during CLEAR restarts c at 0.
- mem_wEn is registered and never high in FROZEN.
- idx never exceeds POINTS-1; max address EMG_BASE+319 = 12'h7EC.
- DECIM=1: every sample is written.

Test Plan:
- Clear after reset: deassert reset, hold valids low -> 640 consecutive writes of data 32'h800; addresses 0x559..0x698 then 0x6AD..0x7EC; busy falls at cycle 641; ready rises.
- ECG decimation: DECIM=4, 8 back-to-back ECG samples 0x100..0x107 -> exactly 2 writes: 0x100 to 0x559, then 0x104 to 0x55A.
- Arbitration: both channels offer with DECIM=1 in the same cycle -> ECG to 0x559 in cycle N+1, EMG to 0x6AD in N+2; on the next contested pair EMG wins first.
- Wrap: DECIM=1, 321 ECG samples -> write 320 goes to 0x698 with ecg_sweep_done=1 for that cycle only; write 321 goes to 0x559.
- Freeze: assert freeze after 10 ECG writes, feed 50 samples -> ready stays 1, zero writes; deassert, feed one sample -> written to 0x559+10.
- Reset/clear mid-operation: clear_req at clear count 300 -> count restarts at 0 (next address 0x559); reset while an EMG hold is pending -> no EMG write occurs, and a fresh 640-write clear follows.
